bitseq_seq_ctrl: RTL and testbench
==================================

Name: bitseq_seq_ctrl

Overview:
Command-driven controller that configures and sequences the multi-channel bit-sequence looper (bitseq_looper_top_v2). It accepts host commands over a valid/ready interface and keeps shadow registers that drive the looper's packed len/rate/phase buses. It serializes pattern words into single-bit memory writes, and issues start/stop/arm/group-start pulses. It sits between the host command decoder and the looper.

Parameters:
NCH, 4, number of looper channels
AW, 4, per-channel pattern address width (depth 2^AW); AW<=12 required
CHW, (NCH<=1)?1:$clog2(NCH), channel index width (derived)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept
cmd_op  in  3  opcode
cmd_ch  in  CHW  target channel
cmd_data  in  32  payload
playing  in  NCH  looper per-channel playing status
err_clr  in  1  clear err_busy
start_ch_bus / stop_ch_bus  out  NCH  one-cycle per-channel pulses
sync_enable  out  1  looper sync-mode level
arm_mask_in  out  NCH  arm bitmap
arm_load / group_start  out  1  one-cycle pulses
len_bus  out  NCH*(AW+1)  packed lengths, ch k at [k*(AW+1)+:AW+1]
rate_div_bus / phase_off_bus  out  NCH*32  packed, ch k at [k*32+:32]
wr_en, wr_ch[CHW], wr_addr[AW], wr_bit  out  pattern write port
busy  out  1  FSM not IDLE
err_busy  out  1  sticky: pattern write refused or aborted

Behaviour:
- Reset (rst sampled high at an edge): all outputs and shadow registers are 0, FSM is IDLE. cmd_ready is 1 from the first cycle after rst deasserts.
- Handshake: accept on cmd_valid&&cmd_ready. cmd_ready = (state==IDLE). All outputs are registered. Effects of a command accepted at edge N appear after edge N+1.
- Opcodes:
  - 0 NOP: no effect.
  - 1 SET_LEN: len[ch] = data[AW:0]. Values above 2^AW clamp to 2^AW.
  - 2 SET_RATE: rate[ch] = data.
  - 3 SET_PHASE: phase[ch] = data.
  - 4 LOAD_BITS: bits = data[15:0], LSB first. count = data[19:16]+1 (1..16). base = data[20+:AW]. Addresses wrap mod 2^AW.
  - 5 START: start_ch_bus[ch] pulses 1 cycle.
  - 6 STOP: stop_ch_bus[ch] pulses 1 cycle.
  - 7 GROUP: sync_enable = data[31]; arm_mask_in = data[NCH-1:0]; arm_load pulses. If data[30] is set, group_start also pulses.
- SET_* commands are allowed while playing; the looper samples the buses at start.
- FSM states and transitions:
  - IDLE: wait for an accepted command.
  - IDLE to WRITE on LOAD_BITS when playing[ch]==0. wr_en is high for exactly count cycles (N+1..N+count). wr_ch is held; wr_addr runs base..base+count-1 (wrapping); wr_bit = bits[i]. Return to IDLE after the last bit, so cmd_ready is 1 at N+count+1.
  - LOAD_BITS with playing[ch]==1 at accept: no writes, err_busy set at N+1, stay in IDLE.
  - playing[wr_ch] rising during WRITE: drop wr_en next cycle, set err_busy, return to IDLE.
  - GROUP: ARM (arm_load at N+1), then GAP, then GSTART (group_start at N+3, only if data[30] is set), then IDLE. With data[30]=0, return to IDLE after GAP.
- START/STOP/SET/NOP stay in IDLE, so back-to-back commands are accepted every cycle.
- err_busy: a set and err_clr in the same cycle leaves err_busy=1 (set wins).
- Reset mid-WRITE or mid-GROUP: sequence aborts and all pulses/wr_en are 0 after the reset edge.

Optional Feature:
BITSEQ_SEQ_CMDFIFO_EN:
- Defined: a 4-entry command FIFO sits in front of the FSM. cmd_ready = !fifo_full; the FSM pops when IDLE and the FIFO is not empty. This adds one cycle of latency to all command effects. Reset empties the FIFO.
- Undefined: direct path, cmd_ready = (state==IDLE).

Decomposition:
- Package bitseq_seq_pkg:
  - opcode localparams OP_NOP..OP_GROUP
  - FSM state encoding IDLE/WRITE/ARM/GAP/GSTART
  - payload field positions (count, base, group flag bits)
- Sub-module bitseq_seq_cmd_fifo: a parameterized synchronous FIFO of {op,ch,data}. It is instantiated only under BITSEQ_SEQ_CMDFIFO_EN.

Test Plan:
1. Reset: hold rst 3 cycles, then release. All outputs are 0 and cmd_ready=1 in the first cycle after release.
2. SET_LEN ch1 data=10, SET_RATE ch2 data=49, sent back to back. Next cycles show len_bus[9:5]=10 and rate_div_bus[95:64]=49; cmd_ready never drops.
3. LOAD_BITS ch0 data=0x00090155. Expect 10 wr_en cycles with wr_addr 0..9 and wr_bit 1,0,1,0,1,0,1,0,1,0; cmd_ready is low for exactly 10 cycles.
4. LOAD_BITS ch3 with count 4 and base 14. Expect wr_addr 14,15,0,1 (wrap).
5. playing[2]=1, then LOAD_BITS ch2: no wr_en and err_busy=1. Pulse err_clr and err_busy=0. Repeat with err_clr coinciding with a new error: err_busy stays 1.
6. GROUP data=0xC000000F: sync_enable=1, arm_mask_in=4'hF, arm_load at N+1, group_start at N+3, cmd_ready back at N+4. With the macro defined, every timing shifts by +1 and 4 commands are accepted while WRITE is active.

Source files
------------

// File: rtl/bitseq_seq_pkg.sv
// Shared opcodes, FSM encoding and payload field positions for the looper sequencing controller.
package bitseq_seq_pkg;

    localparam logic [2:0] OP_NOP       = 3'd0;
    localparam logic [2:0] OP_SET_LEN   = 3'd1;
    localparam logic [2:0] OP_SET_RATE  = 3'd2;
    localparam logic [2:0] OP_SET_PHASE = 3'd3;
    localparam logic [2:0] OP_LOAD_BITS = 3'd4;
    localparam logic [2:0] OP_START     = 3'd5;
    localparam logic [2:0] OP_STOP      = 3'd6;
    localparam logic [2:0] OP_GROUP     = 3'd7;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WRITE  = 3'd1;
    localparam logic [2:0] ST_ARM    = 3'd2;
    localparam logic [2:0] ST_GAP    = 3'd3;
    localparam logic [2:0] ST_GSTART = 3'd4;

    localparam int BITS_LSB      = 0;
    localparam int BITS_W        = 16;
    localparam int CNT_LSB       = 16;
    localparam int CNT_W         = 4;
    localparam int BASE_LSB      = 20;
    localparam int GRP_START_BIT = 30;
    localparam int GRP_SYNC_BIT  = 31;

    // LOAD_BITS encodes count-1 so that a zero field still writes one bit.
    function automatic logic [4:0] load_count(input logic [31:0] data);
        return {1'b0, data[CNT_LSB +: CNT_W]} + 5'd1;
    endfunction

endpackage

// File: rtl/bitseq_seq_cmd_fifo.sv
// Small synchronous FIFO holding {op, ch, data} commands ahead of the controller FSM.
module bitseq_seq_cmd_fifo
    import bitseq_seq_pkg::*;
#(
    parameter int W     = 37,
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         empty_o,
    output logic         full_o
);

    localparam int PW = (DEPTH <= 1) ? 1 : $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH-1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH-1)) ? '0 : rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; only the pointers define which entries are live.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/bitseq_seq_ctrl.sv
// Command-driven controller that configures and sequences the bit-sequence looper.
// Define BITSEQ_SEQ_CMDFIFO_EN to place a 4-entry command FIFO in front of the FSM.
module bitseq_seq_ctrl
    import bitseq_seq_pkg::*;
#(
    parameter int NCH = 4,
    parameter int AW  = 4,
    parameter int CHW = (NCH <= 1) ? 1 : $clog2(NCH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic [CHW-1:0]        cmd_ch,
    input  logic [31:0]           cmd_data,
    input  logic [NCH-1:0]        playing,
    input  logic                  err_clr,
    output logic [NCH-1:0]        start_ch_bus,
    output logic [NCH-1:0]        stop_ch_bus,
    output logic                  sync_enable,
    output logic [NCH-1:0]        arm_mask_in,
    output logic                  arm_load,
    output logic                  group_start,
    output logic [NCH*(AW+1)-1:0] len_bus,
    output logic [NCH*32-1:0]     rate_div_bus,
    output logic [NCH*32-1:0]     phase_off_bus,
    output logic                  wr_en,
    output logic [CHW-1:0]        wr_ch,
    output logic [AW-1:0]         wr_addr,
    output logic                  wr_bit,
    output logic                  busy,
    output logic                  err_busy
);

    localparam logic [31:0] LEN_MAX = 32'(1) << AW;

    logic [2:0]            state_q, state_d;
    logic [NCH*(AW+1)-1:0] len_q, len_d;
    logic [NCH*32-1:0]     rate_q, rate_d;
    logic [NCH*32-1:0]     phase_q, phase_d;
    logic [NCH-1:0]        start_q, start_d;
    logic [NCH-1:0]        stop_q, stop_d;
    logic                  sync_q, sync_d;
    logic [NCH-1:0]        arm_mask_q, arm_mask_d;
    logic                  arm_load_q, arm_load_d;
    logic                  gstart_q, gstart_d;
    logic                  wr_en_q, wr_en_d;
    logic [CHW-1:0]        wr_ch_q, wr_ch_d;
    logic [AW-1:0]         wr_addr_q, wr_addr_d;
    logic                  wr_bit_q, wr_bit_d;
    logic                  err_q, err_d;
    logic [BITS_W-1:0]     bits_q, bits_d;
    logic [4:0]            cnt_q, cnt_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic                  pend_valid_q, pend_valid_d;
    logic [2:0]            pend_op_q, pend_op_d;
    logic [CHW-1:0]        pend_ch_q, pend_ch_d;
    logic [31:0]           pend_data_q, pend_data_d;

    logic                  src_valid;
    logic [2:0]            src_op;
    logic [CHW-1:0]        src_ch;
    logic [31:0]           src_data;
    logic                  take;
    logic                  err_set;
    logic [AW:0]           len_val;

`ifdef BITSEQ_SEQ_CMDFIFO_EN
    localparam int FW = 3 + CHW + 32;

    logic          fifo_empty;
    logic          fifo_full;
    logic [FW-1:0] fifo_dout;

    bitseq_seq_cmd_fifo #(
        .W     (FW),
        .DEPTH (4)
    ) u_cmd_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (cmd_valid && cmd_ready),
        .din_i   ({cmd_op, cmd_ch, cmd_data}),
        .pop_i   (take),
        .dout_o  (fifo_dout),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    assign cmd_ready = !fifo_full && !rst;
    assign src_valid = !fifo_empty;
    assign {src_op, src_ch, src_data} = fifo_dout;
`else
    assign cmd_ready = (state_q == ST_IDLE) && !rst;
    assign src_valid = cmd_valid;
    assign src_op    = cmd_op;
    assign src_ch    = cmd_ch;
    assign src_data  = cmd_data;
`endif

    assign take    = src_valid && (state_q == ST_IDLE);
    assign len_val = (pend_data_q > LEN_MAX) ? LEN_MAX[AW:0] : pend_data_q[AW:0];

    // A command taken in IDLE is staged for one cycle, so its effect lands one edge after acceptance.
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        rate_d       = rate_q;
        phase_d      = phase_q;
        start_d      = '0;
        stop_d       = '0;
        sync_d       = sync_q;
        arm_mask_d   = arm_mask_q;
        arm_load_d   = 1'b0;
        gstart_d     = 1'b0;
        wr_en_d      = 1'b0;
        wr_ch_d      = wr_ch_q;
        wr_addr_d    = wr_addr_q;
        wr_bit_d     = wr_bit_q;
        bits_d       = bits_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        pend_valid_d = 1'b0;
        pend_op_d    = pend_op_q;
        pend_ch_d    = pend_ch_q;
        pend_data_d  = pend_data_q;
        err_set      = 1'b0;

        if (pend_valid_q && (int'(pend_ch_q) < NCH)) begin
            case (pend_op_q)
                OP_SET_LEN:   len_d[int'(pend_ch_q)*(AW+1) +: AW+1] = len_val;
                OP_SET_RATE:  rate_d[int'(pend_ch_q)*32 +: 32]      = pend_data_q;
                OP_SET_PHASE: phase_d[int'(pend_ch_q)*32 +: 32]     = pend_data_q;
                OP_START:     start_d[pend_ch_q]                    = 1'b1;
                OP_STOP:      stop_d[pend_ch_q]                     = 1'b1;
                OP_LOAD_BITS: err_set                               = 1'b1;
                default:      ;
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                if (take) begin
                    pend_op_d   = src_op;
                    pend_ch_d   = src_ch;
                    pend_data_d = src_data;
                    if (src_op == OP_LOAD_BITS && !playing[src_ch]) begin
                        state_d = ST_WRITE;
                        wr_ch_d = src_ch;
                        bits_d  = src_data[BITS_LSB +: BITS_W];
                        cnt_d   = load_count(src_data);
                        addr_d  = src_data[BASE_LSB +: AW];
                    end else if (src_op == OP_GROUP) begin
                        state_d = ST_ARM;
                    end else begin
                        // A refused LOAD_BITS also takes this path and raises the error when applied.
                        pend_valid_d = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                if (playing[wr_ch_q]) begin
                    err_set = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_bit_d  = bits_q[0];
                    bits_d    = bits_q >> 1;
                    addr_d    = addr_q + AW'(1);
                    cnt_d     = cnt_q - 5'd1;
                    if (cnt_q == 5'd1) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_ARM: begin
                sync_d     = pend_data_q[GRP_SYNC_BIT];
                arm_mask_d = pend_data_q[NCH-1:0];
                arm_load_d = 1'b1;
                state_d    = ST_GAP;
            end
            ST_GAP: begin
                state_d = pend_data_q[GRP_START_BIT] ? ST_GSTART : ST_IDLE;
            end
            ST_GSTART: begin
                gstart_d = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        err_d = (err_q && !err_clr) || err_set;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            rate_q       <= '0;
            phase_q      <= '0;
            start_q      <= '0;
            stop_q       <= '0;
            sync_q       <= 1'b0;
            arm_mask_q   <= '0;
            arm_load_q   <= 1'b0;
            gstart_q     <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_ch_q      <= '0;
            wr_addr_q    <= '0;
            wr_bit_q     <= 1'b0;
            err_q        <= 1'b0;
            bits_q       <= '0;
            cnt_q        <= '0;
            addr_q       <= '0;
            pend_valid_q <= 1'b0;
            pend_op_q    <= '0;
            pend_ch_q    <= '0;
            pend_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            rate_q       <= rate_d;
            phase_q      <= phase_d;
            start_q      <= start_d;
            stop_q       <= stop_d;
            sync_q       <= sync_d;
            arm_mask_q   <= arm_mask_d;
            arm_load_q   <= arm_load_d;
            gstart_q     <= gstart_d;
            wr_en_q      <= wr_en_d;
            wr_ch_q      <= wr_ch_d;
            wr_addr_q    <= wr_addr_d;
            wr_bit_q     <= wr_bit_d;
            err_q        <= err_d;
            bits_q       <= bits_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            pend_valid_q <= pend_valid_d;
            pend_op_q    <= pend_op_d;
            pend_ch_q    <= pend_ch_d;
            pend_data_q  <= pend_data_d;
        end
    end

    assign start_ch_bus  = start_q;
    assign stop_ch_bus   = stop_q;
    assign sync_enable   = sync_q;
    assign arm_mask_in   = arm_mask_q;
    assign arm_load      = arm_load_q;
    assign group_start   = gstart_q;
    assign len_bus       = len_q;
    assign rate_div_bus  = rate_q;
    assign phase_off_bus = phase_q;
    assign wr_en         = wr_en_q;
    assign wr_ch         = wr_ch_q;
    assign wr_addr       = wr_addr_q;
    assign wr_bit        = wr_bit_q;
    assign busy          = (state_q != ST_IDLE);
    assign err_busy      = err_q;

endmodule

// File: tb/tb_bitseq_seq_ctrl.sv
// Directed, table-driven bench for bitseq_seq_ctrl (default build; BITSEQ_SEQ_CMDFIFO_EN shifts timing by one).
module tb_bitseq_seq_ctrl;

`ifdef BITSEQ_SEQ_CMDFIFO_EN
    localparam int XL = 1;
`else
    localparam int XL = 0;
`endif

    localparam int NCH = 4;
    localparam int AW  = 4;
    localparam int CHW = 2;

    logic                  clk;
    logic                  rst;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [2:0]            cmd_op;
    logic [CHW-1:0]        cmd_ch;
    logic [31:0]           cmd_data;
    logic [NCH-1:0]        playing;
    logic                  err_clr;
    logic [NCH-1:0]        start_ch_bus;
    logic [NCH-1:0]        stop_ch_bus;
    logic                  sync_enable;
    logic [NCH-1:0]        arm_mask_in;
    logic                  arm_load;
    logic                  group_start;
    logic [NCH*(AW+1)-1:0] len_bus;
    logic [NCH*32-1:0]     rate_div_bus;
    logic [NCH*32-1:0]     phase_off_bus;
    logic                  wr_en;
    logic [CHW-1:0]        wr_ch;
    logic [AW-1:0]         wr_addr;
    logic                  wr_bit;
    logic                  busy;
    logic                  err_busy;

    int testCount = 0;
    int failCount = 0;

    typedef struct {
        logic [2:0]  op;
        logic [1:0]  ch;
        logic [31:0] data;
        int          kind;
        logic [31:0] expVal;
    } vec_t;

    vec_t vecs[11];

    bitseq_seq_ctrl #(.NCH(NCH), .AW(AW), .CHW(CHW)) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_ch        (cmd_ch),
        .cmd_data      (cmd_data),
        .playing       (playing),
        .err_clr       (err_clr),
        .start_ch_bus  (start_ch_bus),
        .stop_ch_bus   (stop_ch_bus),
        .sync_enable   (sync_enable),
        .arm_mask_in   (arm_mask_in),
        .arm_load      (arm_load),
        .group_start   (group_start),
        .len_bus       (len_bus),
        .rate_div_bus  (rate_div_bus),
        .phase_off_bus (phase_off_bus),
        .wr_en         (wr_en),
        .wr_ch         (wr_ch),
        .wr_addr       (wr_addr),
        .wr_bit        (wr_bit),
        .busy          (busy),
        .err_busy      (err_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Called at a negedge; returns at the negedge just after the accepting edge.
    task automatic applyStimulus(input logic [2:0] op, input logic [1:0] ch, input logic [31:0] data);
        int n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("cmdReadyWait", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_ch    = ch;
        cmd_data  = data;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    function automatic logic [31:0] fieldOf(input int kind, input logic [1:0] ch);
        case (kind)
            0:       return 32'(len_bus[int'(ch)*5 +: 5]);
            1:       return rate_div_bus[int'(ch)*32 +: 32];
            2:       return phase_off_bus[int'(ch)*32 +: 32];
            3:       return 32'(start_ch_bus);
            default: return 32'(stop_ch_bus);
        endcase
    endfunction

    task automatic runLoad(input logic [1:0] ch, input logic [31:0] data);
        int          cnt;
        logic [3:0]  base;
        logic [15:0] bv;
        logic [3:0]  ea;
        int          readyLow = 0;
        bit          expEn;
        cnt  = int'(data[19:16]) + 1;
        base = data[23:20];
        bv   = data[15:0];
        applyStimulus(3'd4, ch, data);
        for (int j = 0; j <= cnt + 4; j++) begin
            expEn = (j >= 1 + XL) && (j <= cnt + XL);
            checkOutput($sformatf("wrEn[%0d]", j), 32'(wr_en), 32'(expEn));
            if (expEn) begin
                ea = base + 4'(j - 1 - XL);
                checkOutput($sformatf("wrAddr[%0d]", j), 32'(wr_addr), 32'(ea));
                checkOutput($sformatf("wrBit[%0d]", j), 32'(wr_bit), 32'(bv[j-1-XL]));
                checkOutput($sformatf("wrCh[%0d]", j), 32'(wr_ch), 32'(ch));
            end
            if (!cmd_ready) readyLow++;
            @(negedge clk);
        end
`ifndef BITSEQ_SEQ_CMDFIFO_EN
        checkOutput("readyLowCycles", 32'(readyLow), 32'(cnt));
`endif
    endtask

    initial begin
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_ch    = '0;
        cmd_data  = '0;
        playing   = '0;
        err_clr   = 1'b0;
        rst       = 1'b1;

        vecs[0]  = '{3'd1, 2'd0, 32'd17,        0, 32'd16};
        vecs[1]  = '{3'd1, 2'd3, 32'd16,        0, 32'd16};
        vecs[2]  = '{3'd1, 2'd2, 32'd7,         0, 32'd7};
        vecs[3]  = '{3'd2, 2'd0, 32'h12345678,  1, 32'h12345678};
        vecs[4]  = '{3'd3, 2'd1, 32'hDEADBEEF,  2, 32'hDEADBEEF};
        vecs[5]  = '{3'd3, 2'd3, 32'h80000001,  2, 32'h80000001};
        vecs[6]  = '{3'd5, 2'd2, 32'd0,         3, 32'h4};
        vecs[7]  = '{3'd6, 2'd1, 32'd0,         4, 32'h2};
        vecs[8]  = '{3'd0, 2'd1, 32'd3,         0, 32'd10};
        vecs[9]  = '{3'd1, 2'd1, 32'hFFFFFFFF,  0, 32'd16};
        vecs[10] = '{3'd5, 2'd0, 32'd0,         4, 32'h0};

        // Reset held for three edges, then released.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rstReady", 32'(cmd_ready), 32'd1);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstErr", 32'(err_busy), 32'd0);
        checkOutput("rstLen", 32'(len_bus), 32'd0);
        checkOutput("rstRate", 32'(|rate_div_bus), 32'd0);
        checkOutput("rstPhase", 32'(|phase_off_bus), 32'd0);
        checkOutput("rstPulses", 32'({start_ch_bus, stop_ch_bus, arm_load, group_start}), 32'd0);
        checkOutput("rstGroup", 32'({sync_enable, arm_mask_in}), 32'd0);
        checkOutput("rstWrite", 32'({wr_en, wr_ch, wr_addr, wr_bit}), 32'd0);

        // Back-to-back SET_LEN / SET_RATE.
        cmd_valid = 1'b1; cmd_op = 3'd1; cmd_ch = 2'd1; cmd_data = 32'd10;
        checkOutput("b2bReady0", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_op = 3'd2; cmd_ch = 2'd2; cmd_data = 32'd49;
        checkOutput("b2bReady1", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        checkOutput("b2bReady2", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        repeat (XL) @(negedge clk);
        checkOutput("b2bLen1", 32'(len_bus[9:5]), 32'd10);
        checkOutput("b2bRate2", rate_div_bus[95:64], 32'd49);

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].op, vecs[i].ch, vecs[i].data);
            repeat (1 + XL) @(negedge clk);
            checkOutput($sformatf("vec%0d", i), fieldOf(vecs[i].kind, vecs[i].ch), vecs[i].expVal);
        end
        checkOutput("lenBusAll", 32'(len_bus), 32'h81E10);

        runLoad(2'd0, 32'h00090155);
        runLoad(2'd3, 32'h00E3000B);

        // Refused load, clear, then clear colliding with a new refusal.
        playing = 4'b0100;
        applyStimulus(3'd4, 2'd2, 32'h00030005);
        for (int j = 0; j < 6; j++) begin
            checkOutput($sformatf("refWrEn[%0d]", j), 32'(wr_en), 32'd0);
            checkOutput($sformatf("refErr[%0d]", j), 32'(err_busy), 32'(j >= 1 + XL));
            @(negedge clk);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checkOutput("errCleared", 32'(err_busy), 32'd0);
        applyStimulus(3'd4, 2'd2, 32'h00030005);
        repeat (XL) @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checkOutput("errSetWins", 32'(err_busy), 32'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        playing = '0;
        checkOutput("errCleared2", 32'(err_busy), 32'd0);

        // playing rises mid-write.
        applyStimulus(3'd4, 2'd1, 32'h00070000);
        repeat (2 + XL) @(negedge clk);
        checkOutput("abortPre", 32'(wr_en), 32'd1);
        playing = 4'b0010;
        @(negedge clk);
        checkOutput("abortWrEn", 32'(wr_en), 32'd0);
        checkOutput("abortErr", 32'(err_busy), 32'd1);
        checkOutput("abortBusy", 32'(busy), 32'd0);
        playing = '0;
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;

        // GROUP with group_start.
        applyStimulus(3'd7, 2'd0, 32'hC000000F);
        for (int j = 0; j < 6; j++) begin
            checkOutput($sformatf("gArm[%0d]", j), 32'(arm_load), 32'(j == 1 + XL));
            checkOutput($sformatf("gStart[%0d]", j), 32'(group_start), 32'(j == 3 + XL));
`ifndef BITSEQ_SEQ_CMDFIFO_EN
            checkOutput($sformatf("gReady[%0d]", j), 32'(cmd_ready), 32'(j >= 3));
`endif
            @(negedge clk);
        end
        checkOutput("gSync", 32'(sync_enable), 32'd1);
        checkOutput("gMask", 32'(arm_mask_in), 32'hF);

        // GROUP without group_start.
        applyStimulus(3'd7, 2'd0, 32'h00000005);
        for (int j = 0; j < 5; j++) begin
            checkOutput($sformatf("g2Arm[%0d]", j), 32'(arm_load), 32'(j == 1 + XL));
            checkOutput($sformatf("g2Start[%0d]", j), 32'(group_start), 32'd0);
`ifndef BITSEQ_SEQ_CMDFIFO_EN
            checkOutput($sformatf("g2Ready[%0d]", j), 32'(cmd_ready), 32'(j >= 2));
`endif
            @(negedge clk);
        end
        checkOutput("g2Sync", 32'(sync_enable), 32'd0);
        checkOutput("g2Mask", 32'(arm_mask_in), 32'h5);

`ifdef BITSEQ_SEQ_CMDFIFO_EN
        // Commands queue up while a write is in progress.
        applyStimulus(3'd4, 2'd0, 32'h000F0000);
        for (int k = 0; k < 4; k++) begin
            cmd_valid = 1'b1; cmd_op = 3'd2; cmd_ch = 2'(k); cmd_data = 32'(100 + k);
            checkOutput($sformatf("fifoReady%0d", k), 32'(cmd_ready), 32'd1);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        checkOutput("fifoFull", 32'(cmd_ready), 32'd0);
        repeat (24) @(negedge clk);
        checkOutput("fifoRate3", rate_div_bus[127:96], 32'd103);
`endif

        // Reset in the middle of a write.
        applyStimulus(3'd4, 2'd0, 32'h000F0000);
        repeat (3 + XL) @(negedge clk);
        checkOutput("rwPre", 32'(wr_en), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rwWrEn", 32'(wr_en), 32'd0);
        checkOutput("rwBusy", 32'(busy), 32'd0);
        checkOutput("rwLen", 32'(len_bus), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rwReady", 32'(cmd_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
